// File: rtl/morse_pkg.sv
// Shared types and Morse digit table for the serial Morse decoder.
// code[4] is the first symbol sent; 1 = dot, 0 = dash.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2
  } morse_state_e;

  localparam logic DOT  = 1'b1;
  localparam logic DASH = 1'b0;

  localparam logic [4:0] CODE_0 = 5'b00000;
  localparam logic [4:0] CODE_1 = 5'b10000;
  localparam logic [4:0] CODE_2 = 5'b11000;
  localparam logic [4:0] CODE_3 = 5'b11100;
  localparam logic [4:0] CODE_4 = 5'b11110;
  localparam logic [4:0] CODE_5 = 5'b11111;
  localparam logic [4:0] CODE_6 = 5'b01111;
  localparam logic [4:0] CODE_7 = 5'b00111;
  localparam logic [4:0] CODE_8 = 5'b00011;
  localparam logic [4:0] CODE_9 = 5'b00001;

  localparam logic [3:0] DIGIT_ERR = 4'hF;

endpackage

// File: rtl/decodificador_morse_serial_if.sv
// Result bus of the Morse decoder: registered result plus valid/ready handshake.
// The decoder drives through master; the consumer samples through slave.
interface decodificador_morse_serial_if;
  logic       ready;
  logic [3:0] digit;
  logic [4:0] code;
  logic       err;
  logic       valid;
  logic       overrun;

  modport master (input ready, output digit, code, err, valid, overrun);
  modport slave  (output ready, input digit, code, err, valid, overrun);
endinterface

// File: rtl/morse_codigo_para_digito.sv
// Table lookup from a 5-symbol Morse code to its decimal digit.
// Purely combinational; hit=0 and digit=DIGIT_ERR for codes outside the table.
module morse_codigo_para_digito
  import morse_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit,
  output logic       hit
);

  always_comb begin
    digit = DIGIT_ERR;
    hit   = 1'b1;
    case (code)
      CODE_0:  digit = 4'd0;
      CODE_1:  digit = 4'd1;
      CODE_2:  digit = 4'd2;
      CODE_3:  digit = 4'd3;
      CODE_4:  digit = 4'd4;
      CODE_5:  digit = 4'd5;
      CODE_6:  digit = 4'd6;
      CODE_7:  digit = 4'd7;
      CODE_8:  digit = 4'd8;
      CODE_9:  digit = 4'd9;
      default: hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/decodificador_morse_serial.sv
// Serial Morse digit receiver; result registered 1 cycle after the 3*UNIT-th gap sample.
// Pending result holds until ready; a new character arriving meanwhile is dropped and sets overrun. Option: MORSE_GLITCH_FILTER_EN.
module decodificador_morse_serial
  import morse_pkg::*;
#(
  parameter int UNIT = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           key,
  decodificador_morse_serial_if.master   res
);

  localparam int CNTW = $clog2(3 * UNIT) + 1;

  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] DASH_MIN = CNTW'(2 * UNIT);
  localparam logic [CNTW-1:0] GAP_END  = CNTW'(3 * UNIT - 1);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] MARK  = ST_MARK;
  localparam logic [1:0] SPACE = ST_SPACE;

  logic [1:0]      state;
  logic [CNTW-1:0] cnt;
  logic [4:0]      sr;
  logic [2:0]      nsym;
  logic            glitch;
  logic            done;
  logic [3:0]      tbl_digit;
  logic            tbl_hit;
  logic            char_err;

`ifdef MORSE_GLITCH_FILTER_EN
  localparam logic [CNTW-1:0] GLITCH_MIN = CNTW'((UNIT / 2 > 1) ? UNIT / 2 : 1);
  assign glitch = (cnt < GLITCH_MIN);
`else
  assign glitch = 1'b0;
`endif

  assign done = (state == SPACE) && !key && (cnt == GAP_END);

  morse_codigo_para_digito u_tabla (
    .code  (sr),
    .digit (tbl_digit),
    .hit   (tbl_hit)
  );

  assign char_err = (nsym != 3'd5) || !tbl_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      nsym  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key) begin
            state <= MARK;
            cnt   <= CNT_ONE;
            sr    <= '0;
            nsym  <= '0;
          end
        end
        MARK: begin
          if (key) begin
            if (cnt != DASH_MIN) cnt <= cnt + CNT_ONE;
          end else if (glitch) begin
            // A too-short pulse leaves no trace; with no symbols yet it never started a character.
            state <= (nsym == 3'd0) ? IDLE : SPACE;
            cnt   <= CNT_ONE;
          end else begin
            sr    <= {sr[3:0], (cnt < DASH_MIN) ? DOT : DASH};
            if (nsym != 3'd6) nsym <= nsym + 3'd1;
            state <= SPACE;
            cnt   <= CNT_ONE;
          end
        end
        SPACE: begin
          if (key) begin
            state <= MARK;
            cnt   <= CNT_ONE;
          end else if (cnt == GAP_END) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res.digit   <= '0;
      res.code    <= '0;
      res.err     <= 1'b0;
      res.valid   <= 1'b0;
      res.overrun <= 1'b0;
    end else if (done && (!res.valid || res.ready)) begin
      res.digit <= char_err ? DIGIT_ERR : tbl_digit;
      res.code  <= sr;
      res.err   <= char_err;
      res.valid <= 1'b1;
    end else if (done) begin
      res.overrun <= 1'b1;
    end else if (res.valid && res.ready) begin
      res.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decodificador_morse_serial.sv
// Randomized bench for the Morse decoder against a mark-length reference model.
// Honours MORSE_GLITCH_FILTER_EN so it matches whichever build it is compiled with.
module tb_decodificador_morse_serial;

  localparam int U = 8;
`ifdef MORSE_GLITCH_FILTER_EN
  localparam bit GF = 1'b1;
`else
  localparam bit GF = 1'b0;
`endif
  localparam int GMIN = GF ? U / 2 : 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [4:0] tbl [10] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
                           5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001};

  int         mk [8];
  int         gp [8];
  int         nm;
  logic [3:0] e_digit;
  logic [4:0] e_code;
  logic       e_err;

  decodificador_morse_serial_if bus ();

  decodificador_morse_serial #(.UNIT(U)) dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .res   (bus)
  );

  always #5 clk = ~clk;

  task automatic hold(input logic v, input int n);
    repeat (n) begin
      key = v;
      @(negedge clk);
    end
  endtask

  // Plays the marks/gaps in mk/gp, then a full character gap; optionally raises ready on the final edge.
  task automatic play(input logic rdy_last);
    for (int i = 0; i < nm; i++) begin
      hold(1'b1, mk[i]);
      if (i < nm - 1) hold(1'b0, gp[i]);
    end
    hold(1'b0, 3 * U - 1);
    bus.ready = rdy_last;
    hold(1'b0, 1);
    bus.ready = 1'b0;
  endtask

  task automatic accept();
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
  endtask

  // Reference: every kept mark becomes a symbol, the last five form the code.
  function automatic void model();
    int         n = 0;
    logic [4:0] c = 5'b0;
    for (int i = 0; i < nm; i++) begin
      if (GF && mk[i] < GMIN) continue;
      c = {c[3:0], (mk[i] < 2 * U) ? 1'b1 : 1'b0};
      n++;
    end
    e_code  = c;
    e_err   = 1'b1;
    e_digit = 4'hF;
    if (n == 5) begin
      for (int d = 0; d < 10; d++) begin
        if (tbl[d] == c) begin
          e_err   = 1'b0;
          e_digit = 4'(d);
        end
      end
    end
  endfunction

  function automatic void build_digit(input int d);
    logic [4:0] c = tbl[d];
    nm = 5;
    for (int i = 0; i < 5; i++) begin
      mk[i] = c[4 - i] ? $urandom_range(2 * U - 1, GMIN) : $urandom_range(30, 2 * U);
      gp[i] = $urandom_range(3 * U - 1, 1);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    key = 1'b0;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.digit, bus.code, bus.err, bus.valid, bus.overrun} !== 12'b0) begin
      bad++;
      $display("FAIL reset digit=%h code=%b err=%b valid=%b overrun=%b want all 0",
               bus.digit, bus.code, bus.err, bus.valid, bus.overrun);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_threshold();
    for (int len = 2 * U - 1; len <= 2 * U; len++) begin
      nm = 5;
      for (int i = 0; i < 5; i++) begin
        mk[i] = len;
        gp[i] = U;
      end
      play(1'b0);
      total++;
      if (bus.valid !== 1'b1 || bus.code !== ((len < 2 * U) ? 5'b11111 : 5'b00000) ||
          bus.digit !== ((len < 2 * U) ? 4'd5 : 4'd0) || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL threshold len=%0d valid=%b code=%b digit=%h err=%b",
                 len, bus.valid, bus.code, bus.digit, bus.err);
      end
      accept();
      total++;
      if (bus.valid !== 1'b0) begin
        bad++;
        $display("FAIL threshold_accept valid=%b want 0", bus.valid);
      end
    end
  endtask

  task automatic test_random_chars();
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 2) begin
        nm = $urandom_range(7, 1);
        for (int i = 0; i < nm; i++) begin
          mk[i] = $urandom_range(30, GMIN);
          gp[i] = $urandom_range(3 * U - 1, 1);
        end
      end else begin
        build_digit($urandom_range(9, 0));
      end
      model();
      play(1'b0);
      total++;
      if (bus.valid !== 1'b1 || bus.digit !== e_digit || bus.code !== e_code || bus.err !== e_err) begin
        bad++;
        $display("FAIL random_char k=%0d got v=%b d=%h c=%b e=%b want v=1 d=%h c=%b e=%b",
                 k, bus.valid, bus.digit, bus.code, bus.err, e_digit, e_code, e_err);
      end
      accept();
    end
  endtask

  task automatic test_length_errors();
    for (int t = 0; t < 3; t++) begin
      nm = (t == 0) ? 3 : (t == 1) ? 6 : 5;
      for (int i = 0; i < nm; i++) begin
        mk[i] = (t == 2 && i > 1) ? 24 : U;
        gp[i] = (t == 2) ? 3 * U - 1 : U;
      end
      model();
      play(1'b0);
      total++;
      if (bus.valid !== 1'b1 || bus.digit !== e_digit || bus.code !== e_code || bus.err !== e_err) begin
        bad++;
        $display("FAIL length_err t=%0d got v=%b d=%h c=%b e=%b want v=1 d=%h c=%b e=%b",
                 t, bus.valid, bus.digit, bus.code, bus.err, e_digit, e_code, e_err);
      end
      accept();
    end
  endtask

  task automatic test_back_to_back();
    bus.ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.ready = 1'b0;
    build_digit(3);
    play(1'b0);
    build_digit(4);
    play(1'b1);
    total++;
    if (bus.valid !== 1'b1 || bus.digit !== 4'd4 || bus.code !== 5'b11110 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back v=%b d=%h c=%b ovr=%b want v=1 d=4 c=11110 ovr=0",
               bus.valid, bus.digit, bus.code, bus.overrun);
    end
    accept();
  endtask

  task automatic test_handshake();
    build_digit(8);
    play(1'b0);
    build_digit(9);
    play(1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (bus.valid !== 1'b1 || bus.digit !== 4'd8 || bus.code !== 5'b00011 || bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun v=%b d=%h c=%b ovr=%b want v=1 d=8 c=00011 ovr=1",
               bus.valid, bus.digit, bus.code, bus.overrun);
    end
    accept();
    total++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b1) begin
      bad++;
      $display("FAIL handshake_drop v=%b ovr=%b want v=0 ovr=1", bus.valid, bus.overrun);
    end
  endtask

  task automatic test_reset_mid_char();
    nm = 3;
    for (int i = 0; i < 3; i++) begin
      mk[i] = U;
      gp[i] = U;
    end
    for (int i = 0; i < nm; i++) begin
      hold(1'b1, mk[i]);
      if (i < nm - 1) hold(1'b0, gp[i]);
    end
    reset = 1'b1;
    hold(1'b0, 1);
    reset = 1'b0;
    hold(1'b0, 3 * U + 4);
    total++;
    if (bus.valid !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid v=%b ovr=%b want v=0 ovr=0", bus.valid, bus.overrun);
    end
    build_digit(7);
    play(1'b0);
    total++;
    if (bus.valid !== 1'b1 || bus.digit !== 4'd7 || bus.err !== 1'b0 || bus.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_then_7 v=%b d=%h e=%b ovr=%b want v=1 d=7 e=0 ovr=0",
               bus.valid, bus.digit, bus.err, bus.overrun);
    end
    accept();
  endtask

  task automatic test_glitch();
    nm = 6;
    mk[0] = U;     gp[0] = U;
    mk[1] = 3;     gp[1] = U;
    mk[2] = U;     gp[2] = U;
    mk[3] = 3 * U; gp[3] = U;
    mk[4] = 3 * U; gp[4] = U;
    mk[5] = 3 * U; gp[5] = U;
    model();
    play(1'b0);
    total++;
    if (bus.valid !== 1'b1 || bus.digit !== e_digit || bus.code !== e_code || bus.err !== e_err) begin
      bad++;
      $display("FAIL glitch got v=%b d=%h c=%b e=%b want v=1 d=%h c=%b e=%b",
               bus.valid, bus.digit, bus.code, bus.err, e_digit, e_code, e_err);
    end
    accept();
  endtask

  initial begin
    bus.ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_threshold();
    test_random_chars();
    test_length_errors();
    test_back_to_back();
    test_handshake();
    test_reset_mid_char();
    test_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
